// File: rtl/axi_rd_slave.sv
// AXI4 read-channel responder over a 64-bit synchronous memory.
// Two-entry AR buffer; bursts are served in order, one beat per memory read.
module axi_rd_slave #(
   parameter logic [63:0] MEM_BASE = 64'h8000_0000,
   parameter int          MEM_AW   = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        ARID,
   input  logic [63:0]       ARADDR,
   input  logic [7:0]        ARLEN,
   input  logic [2:0]        ARSIZE,
   input  logic [1:0]        ARBURST,
   input  logic              ARLOCK,
   input  logic [3:0]        ARCACHE,
   input  logic [2:0]        ARPORT,
   input  logic [3:0]        ARQOS,
   input  logic [3:0]        ARREGION,
   input  logic              ARVALID,
   output logic              ARREADY,
   output logic [3:0]        RID,
   output logic [63:0]       RDATA,
   output logic [1:0]        RRESP,
   output logic              RLAST,
   output logic              RVALID,
   input  logic              RREADY,
   output logic              mem_ren,
   output logic [MEM_AW-1:0] mem_raddr,
   input  logic [63:0]       mem_rdata,
   output logic [1:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where VALID && READY;
   // once RVALID rises it stays high with RID/RDATA/RRESP/RLAST stable until RREADY.

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ar_t;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RESP = 2'd2} state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   state_t      state, state_nx;
   ar_t         fifo [0:1];
   ar_t         head;
   logic        wr_ptr, rd_ptr;
   logic [1:0]  count;
   logic        push, pop;

   logic [3:0]  b_id;
   logic [63:0] b_addr;
   logic [7:0]  b_len;
   logic [2:0]  b_size;
   logic [1:0]  b_burst;
   logic [7:0]  beat;
   logic [1:0]  resp_q;
   logic        hi_q;

   logic [63:0] ev_addr, ev_off;
   logic [2:0]  ev_size;
   logic [1:0]  ev_burst, ev_resp;
   logic        ev_err, ev_in_range, evaluating;
   logic        handshake, last;
   logic        unused_ok;

   // ARREADY depends only on occupancy, so a pop never frees a slot in the same cycle.
   assign ARREADY = !rst && (count != 2'd2);
   assign push    = ARVALID && ARREADY;
   assign pop     = (state == S_IDLE) && (count != 2'd0);
   assign head    = fifo[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            fifo[wr_ptr] <= '{id: ARID, addr: ARADDR, len: ARLEN, size: ARSIZE, burst: ARBURST};
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Beat evaluation uses the FIFO head when starting a burst, otherwise the burst regs.
   always_comb begin
      ev_addr     = (state == S_IDLE) ? head.addr  : b_addr;
      ev_size     = (state == S_IDLE) ? head.size  : b_size;
      ev_burst    = (state == S_IDLE) ? head.burst : b_burst;
      ev_err      = (ev_size > 3'd3) || ev_burst[1];
      ev_off      = ev_addr - MEM_BASE;
      ev_in_range = (ev_addr >= MEM_BASE) && (ev_off[63:MEM_AW+3] == '0);
      if (ev_err)            ev_resp = RESP_SLVERR;
      else if (!ev_in_range) ev_resp = RESP_DECERR;
      else                   ev_resp = RESP_OKAY;
   end

   assign evaluating = pop || (state == S_ISSUE);
   assign handshake  = (state == S_RESP) && RREADY;
   assign last       = (beat == b_len);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (pop) state_nx = S_RESP;
         S_ISSUE: state_nx = S_RESP;
         S_RESP:  if (RREADY) state_nx = last ? S_IDLE : S_ISSUE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         b_id    <= 4'd0;
         b_addr  <= 64'd0;
         b_len   <= 8'd0;
         b_size  <= 3'd0;
         b_burst <= 2'd0;
         beat    <= 8'd0;
         resp_q  <= RESP_OKAY;
         hi_q    <= 1'b0;
      end else begin
         if (pop) begin
            b_id    <= head.id;
            b_addr  <= head.addr;
            b_len   <= head.len;
            b_size  <= head.size;
            b_burst <= head.burst;
            beat    <= 8'd0;
         end
         if (evaluating) begin
            resp_q <= ev_resp;
            hi_q   <= (ev_size == 3'd2) && ev_addr[2];
         end
         if (handshake && !last) begin
            beat <= beat + 8'd1;
            if (b_burst == BURST_INCR) b_addr <= b_addr + (64'd1 << b_size);
         end
      end
   end

   // mem_rdata is held until the next read strobe, so RDATA stays stable through a stall.
   always_comb begin
      RVALID    = (state == S_RESP);
      RLAST     = RVALID && last;
      RID       = b_id;
      RRESP     = resp_q;
      RDATA     = 64'd0;
      if (RVALID && (resp_q == RESP_OKAY))
         RDATA = hi_q ? {mem_rdata[63:32], mem_rdata[63:32]} : mem_rdata;
      mem_ren   = evaluating && (ev_resp == RESP_OKAY);
      mem_raddr = mem_ren ? ev_off[MEM_AW+2:3] : '0;
      dbg_state = state;
   end

   assign unused_ok = ^{ARLOCK, ARCACHE, ARPORT, ARQOS, ARREGION, ev_off[2:0]};

endmodule

// File: tb/tb_axi_rd_slave.sv
// Directed bench for axi_rd_slave: a memory model answers mem_ren, a scoreboard
// of expected R beats is filled at each AR handshake and drained by a monitor.
module tb_axi_rd_slave;

   localparam logic [63:0] MEM_BASE = 64'h8000_0000;
   localparam int          MEM_AW   = 20;
   localparam logic [63:0] MEM_TOP  = MEM_BASE + (64'd1 << (MEM_AW + 3));
   localparam int          EW       = 71;

   logic              clk;
   logic              rst;
   logic [3:0]        ARID;
   logic [63:0]       ARADDR;
   logic [7:0]        ARLEN;
   logic [2:0]        ARSIZE;
   logic [1:0]        ARBURST;
   logic              ARLOCK;
   logic [3:0]        ARCACHE;
   logic [2:0]        ARPORT;
   logic [3:0]        ARQOS;
   logic [3:0]        ARREGION;
   logic              ARVALID;
   logic              ARREADY;
   logic [3:0]        RID;
   logic [63:0]       RDATA;
   logic [1:0]        RRESP;
   logic              RLAST;
   logic              RVALID;
   logic              RREADY;
   logic              mem_ren;
   logic [MEM_AW-1:0] mem_raddr;
   logic [63:0]       mem_rdata = '0;
   logic [1:0]        dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   logic [EW-1:0]     exp_q[$];
   logic [MEM_AW-1:0] ren_q[$];

   axi_rd_slave #(.MEM_BASE(MEM_BASE), .MEM_AW(MEM_AW)) dut (
      .clk(clk), .rst(rst),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPORT(ARPORT), .ARQOS(ARQOS),
      .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
      .RREADY(RREADY), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
      .mem_rdata(mem_rdata), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   // memory contents: word 0 fixed, other words derived from the index
   function automatic logic [63:0] mem_word(input logic [MEM_AW-1:0] idx);
      if (idx == '0) return 64'h1122_3344_5566_7788;
      return {12'hABC, idx, 12'h123, ~idx};
   endfunction

   always @(posedge clk) if (mem_ren) mem_rdata <= mem_word(mem_raddr);
   always @(negedge clk) if (!rst && mem_ren) ren_q.push_back(mem_raddr);

   // expected beats of one request, in order
   function automatic void push_exp(input logic [3:0] id, input logic [63:0] addr,
                                    input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst);
      logic [63:0] a, off, w, d;
      logic [1:0]  resp;
      a = addr;
      for (int b = 0; b <= int'(len); b++) begin
         off = a - MEM_BASE;
         w   = mem_word(off[MEM_AW+2:3]);
         if (size > 3'd3 || burst == 2'b10 || burst == 2'b11) begin
            resp = 2'b10; d = '0;
         end else if (a < MEM_BASE || a >= MEM_TOP) begin
            resp = 2'b11; d = '0;
         end else begin
            resp = 2'b00;
            d = (size == 3'd2 && a[2]) ? {w[63:32], w[63:32]} : w;
         end
         exp_q.push_back({id, resp, (b == int'(len)), d});
         if (burst == 2'b01) a = a + (64'd1 << size);
      end
   endfunction

   // scoreboard monitor: every valid beat must equal the queue head; pop on handshake
   always @(negedge clk) begin
      if (!rst && RVALID) begin
         n_cmp++;
         assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL r_unexpected: observed beat id=%0h resp=%0h data=%0h required none",
                   RID, RRESP, RDATA);
         end
         if (exp_q.size() != 0) begin
            n_cmp++;
            assert ({RID, RRESP, RLAST, RDATA} === exp_q[0]) else begin
               n_err++;
               $error("FAIL r_beat: observed id=%0h resp=%0h last=%0b data=%0h required %0h",
                      RID, RRESP, RLAST, RDATA, exp_q[0]);
            end
            if (RREADY) void'(exp_q.pop_front());
         end
         n_cmp++;
         assert (mem_ren === 1'b0) else begin
            n_err++;
            $error("FAIL ren_in_resp: observed %0b required 0", mem_ren);
         end
      end
   end

   // driver tasks
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic drive_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
      @(posedge clk); #1;
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
      ARVALID = 1'b1;
   endtask

   task automatic accept_ar(output int c);
      logic ok;
      ok = 1'b0;
      c  = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ARREADY === 1'b1) begin
            c  = cyc;
            ok = 1'b1;
            push_exp(ARID, ARADDR, ARLEN, ARSIZE, ARBURST);
            @(posedge clk); #1;
            ARVALID = 1'b0;
            break;
         end
      end
      chk("ar_accept", {63'd0, ok}, 64'd1);
   endtask

   task automatic do_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst, output int c);
      drive_ar(id, addr, len, size, burst);
      accept_ar(c);
   endtask

   task automatic wait_beat(output int c);
      logic ok;
      ok = 1'b0;
      c  = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (RVALID === 1'b1 && RREADY === 1'b1) begin
            c = cyc; ok = 1'b1;
            break;
         end
      end
      chk("beat_wait", {63'd0, ok}, 64'd1);
   endtask

   task automatic wait_rvalid(output int c);
      logic ok;
      ok = 1'b0;
      c  = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (RVALID === 1'b1) begin
            c = cyc; ok = 1'b1;
            break;
         end
      end
      chk("rvalid_wait", {63'd0, ok}, 64'd1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic set_rready(input logic v);
      @(posedge clk); #1;
      RREADY = v;
   endtask

   // directed sequence
   initial begin
      int c, h0, h1, h2, h3;
      rst = 1'b1; RREADY = 1'b1; ARVALID = 1'b0;
      ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
      ARLOCK = '0; ARCACHE = '0; ARPORT = '0; ARQOS = '0; ARREGION = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_arready", {63'd0, ARREADY}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rvalid", {63'd0, RVALID}, 64'd0);
      chk("rst_rlast", {63'd0, RLAST}, 64'd0);
      chk("rst_rid", {60'd0, RID}, 64'd0);
      chk("rst_rresp", {62'd0, RRESP}, 64'd0);
      chk("rst_rdata", RDATA, 64'd0);
      chk("rst_mem_ren", {63'd0, mem_ren}, 64'd0);
      chk("rst_mem_raddr", 64'(mem_raddr), 64'd0);
      chk("rst_state", {62'd0, dbg_state}, 64'd0);
      chk("rst_arready_after", {63'd0, ARREADY}, 64'd1);

      // single 4-byte fetch from the upper half of word 0
      do_ar(4'd0, 64'h8000_0004, 8'd0, 3'd2, 2'b01, c);
      @(negedge clk);
      chk("fetch_ren_n1", {63'd0, mem_ren}, 64'd1);
      chk("fetch_raddr", 64'(mem_raddr), 64'd0);
      @(negedge clk);
      chk("fetch_rvalid_n2", {63'd0, RVALID}, 64'd1);
      chk("fetch_rdata_lo", {32'd0, RDATA[31:0]}, 64'h1122_3344);
      wait_drain();

      // 4-beat INCR burst at full throughput
      ren_q.delete();
      do_ar(4'd1, 64'h8000_0010, 8'd3, 3'd3, 2'b01, c);
      wait_beat(h0); wait_beat(h1); wait_beat(h2); wait_beat(h3);
      chk("burst_gap01", 64'(h1 - h0), 64'd2);
      chk("burst_gap12", 64'(h2 - h1), 64'd2);
      chk("burst_gap23", 64'(h3 - h2), 64'd2);
      wait_drain();
      chk("burst_ren_cnt", 64'(ren_q.size()), 64'd4);
      for (int i = 0; i < 4 && i < ren_q.size(); i++)
         chk("burst_raddr", 64'(ren_q[i]), 64'(i + 2));

      // same burst with beat 1 held for four cycles
      ren_q.delete();
      do_ar(4'd1, 64'h8000_0010, 8'd3, 3'd3, 2'b01, c);
      wait_beat(h0);
      set_rready(1'b0);
      wait_rvalid(c);
      chk("bp_beat1_start", 64'(c - h0), 64'd2);
      repeat (2) begin
         @(negedge clk);
         chk("bp_hold_rvalid", {63'd0, RVALID}, 64'd1);
      end
      set_rready(1'b1);
      wait_beat(h1);
      chk("bp_beat1_done", 64'(h1 - h0), 64'd5);
      wait_drain();
      chk("bp_ren_cnt", 64'(ren_q.size()), 64'd4);

      // crossing the low boundary: DECERR then OKAY at word 0
      ren_q.delete();
      do_ar(4'd2, 64'h7FFF_FFF8, 8'd1, 3'd3, 2'b01, c);
      wait_drain();
      chk("low_ren_cnt", 64'(ren_q.size()), 64'd1);
      if (ren_q.size() != 0) chk("low_raddr", 64'(ren_q[0]), 64'd0);

      // crossing the top boundary: last word OKAY then DECERR
      ren_q.delete();
      do_ar(4'd3, MEM_TOP - 64'd8, 8'd1, 3'd3, 2'b01, c);
      wait_drain();
      chk("top_ren_cnt", 64'(ren_q.size()), 64'd1);
      if (ren_q.size() != 0) chk("top_raddr", 64'(ren_q[0]), 64'hFFFFF);

      // WRAP and oversized beats are slave errors with no memory reads
      ren_q.delete();
      do_ar(4'd4, 64'h8000_0000, 8'd2, 3'd3, 2'b10, c);
      do_ar(4'd5, 64'h8000_0008, 8'd0, 3'd4, 2'b01, c);
      wait_drain();
      chk("slverr_ren_cnt", 64'(ren_q.size()), 64'd0);

      // FIXED burst re-reads the same word
      ren_q.delete();
      do_ar(4'd6, 64'h8000_0024, 8'd2, 3'd2, 2'b00, c);
      wait_drain();
      chk("fixed_ren_cnt", 64'(ren_q.size()), 64'd3);
      for (int i = 0; i < 3 && i < ren_q.size(); i++)
         chk("fixed_raddr", 64'(ren_q[i]), 64'd4);

      // buffering: P stalled, A and B fill the FIFO, C waits for a free slot
      set_rready(1'b0);
      do_ar(4'd2, 64'h8000_0040, 8'd1, 3'd3, 2'b01, c);
      wait_rvalid(c);
      do_ar(4'd3, 64'h8000_0048, 8'd0, 3'd2, 2'b01, c);
      do_ar(4'd4, 64'h8000_004C, 8'd0, 3'd2, 2'b01, c);
      drive_ar(4'd5, 64'h8000_0050, 8'd0, 3'd3, 2'b01);
      repeat (3) begin
         @(negedge clk);
         chk("buf_c_blocked", {63'd0, ARREADY}, 64'd0);
      end
      set_rready(1'b1);
      accept_ar(c);
      wait_drain();

      // reset during beat 2 of a LEN7 burst with one request buffered
      do_ar(4'd6, 64'h8000_0100, 8'd7, 3'd3, 2'b01, c);
      do_ar(4'd7, 64'h8000_0200, 8'd0, 3'd3, 2'b01, c);
      wait_beat(h0);
      wait_beat(h1);
      set_rready(1'b0);
      wait_rvalid(c);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_arready", {63'd0, ARREADY}, 64'd0);
      @(negedge clk);
      chk("mid_rst_rvalid", {63'd0, RVALID}, 64'd0);
      @(posedge clk); #1;
      exp_q.delete();
      rst = 1'b0;
      RREADY = 1'b1;
      @(negedge clk);
      chk("post_rst_arready", {63'd0, ARREADY}, 64'd1);
      repeat (20) begin
         @(negedge clk);
         chk("post_rst_no_beat", {63'd0, RVALID}, 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
